// File: rtl/scandoubler_gen_pkg.sv
// Shared timing defaults, counter widths and the pixel-pipeline control word
// used by the scandoubler_gen block.
package scandoubler_pkg;

  localparam int CNT_W  = 10;
  localparam int SYNC_W = 8;

  localparam int LINE_LEN_DEF   = 414;
  localparam int VSYNC_LEN_DEF  = 90;
  localparam int HS_END_DEF     = 384;
  localparam int H_DE_START_DEF = 64;
  localparam int H_DE_END_DEF   = 376;
  localparam int V_DE_START_DEF = 17;
  localparam int V_DE_END_DEF   = 296;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [SYNC_W-1:0] sync_t;

  localparam cnt_t  CNT_MAX  = '1;
  localparam sync_t SYNC_MAX = '1;

  // Column/line qualifiers captured alongside the buffer read so they meet the data.
  typedef struct packed {
    logic hs;
    logic h_de;
    logic v_de;
    logic oob;
    logic dark;
  } pix_ctl_t;

  function automatic cnt_t cnt_sat_inc(input cnt_t v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/scandoubler_gen_if.sv
// Video-side bundle of the scandoubler: 15 kHz source in, doubled stream out.
interface scandoubler_gen_if #(
  parameter int PIX_W = 1
);
  logic             ce_2pix;
  logic             scanlines;
  logic             csync;
  logic [PIX_W-1:0] v_in;
  logic             hs_out;
  logic             vs_out;
  logic             de_out;
  logic [PIX_W-1:0] v_out;
  logic             frame_start;

  modport master (
    output ce_2pix, scanlines, csync, v_in,
    input  hs_out, vs_out, de_out, v_out, frame_start
  );

  modport slave (
    input  ce_2pix, scanlines, csync, v_in,
    output hs_out, vs_out, de_out, v_out, frame_start
  );
endinterface

// File: rtl/scandoubler_gen_linebuf.sv
// Two-half line buffer: simple dual-port RAM with one write port and a
// registered read port.
module scandoubler_linebuf #(
  parameter int PIX_W = 1,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [2**AW];
  logic [PIX_W-1:0] rd_data_q;

  // No reset on the array or read register so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rd_data_q <= mem[raddr];
  end

  assign rdata = rd_data_q;

endmodule

// File: rtl/scandoubler_gen.sv
// Composite-sync 15 kHz to line-doubled scandoubler with separate hs/vs/DE.
// Optional macro SCANLINE_DIM_EN: dark scanlines show half intensity instead of black.
module scandoubler_gen
  import scandoubler_pkg::*;
#(
  parameter int PIX_W      = 1,
  parameter int LINE_LEN   = LINE_LEN_DEF,
  parameter int BUF_AW     = 9,
  parameter int VSYNC_LEN  = VSYNC_LEN_DEF,
  parameter int HS_END     = HS_END_DEF,
  parameter int H_DE_START = H_DE_START_DEF,
  parameter int H_DE_END   = H_DE_END_DEF,
  parameter int V_DE_START = V_DE_START_DEF,
  parameter int V_DE_END   = V_DE_END_DEF
) (
  input logic              clk,
  input logic              rst_n,
  scandoubler_gen_if.slave vid
);

  localparam int    ZX_W       = BUF_AW + 2;
  localparam cnt_t  LINE_LAST  = cnt_t'(LINE_LEN - 1);
  localparam cnt_t  BUF_COLS   = cnt_t'(2**BUF_AW);
  localparam cnt_t  HS_END_C   = cnt_t'(HS_END);
  localparam cnt_t  HDE_START  = cnt_t'(H_DE_START);
  localparam cnt_t  HDE_END    = cnt_t'(H_DE_END);
  localparam cnt_t  VDE_START  = cnt_t'(V_DE_START);
  localparam cnt_t  VDE_END    = cnt_t'(V_DE_END);
  localparam sync_t VSYNC_THR  = sync_t'(VSYNC_LEN);

  logic             ce;
  logic             csync_prev_q, csync_prev_d;
  sync_t            sync_len_q, sync_len_d;
  cnt_t             line_cnt_q, line_cnt_d;
  cnt_t             sd_col_q, sd_col_d;
  logic [ZX_W-1:0]  zx_col_q, zx_col_d;
  logic             scanline_q, scanline_d;
  logic             toggle_q, toggle_d;
  logic             vs_q, vs_d;
  logic             fs_q, fs_d;
  pix_ctl_t         ctl_q, ctl_d;
  logic             hs_q, hs_d;
  logic             de_q, de_d;
  logic [PIX_W-1:0] v_q, v_d;

  logic             line_edge, hsync_edge, vsync_det, col_wrap;
  logic             buf_we;
  logic [BUF_AW-1:0] wcol;
  logic [PIX_W-1:0] rd_data;

  assign ce         = vid.ce_2pix;
  assign line_edge  = vid.csync && !csync_prev_q;
  assign hsync_edge = line_edge && (sync_len_q < VSYNC_THR);
  assign vsync_det  = !vid.csync && (sync_len_q == VSYNC_THR);
  assign col_wrap   = (sd_col_q == LINE_LAST);

  // Writes stop once the column runs past the half; the address parks on the last entry.
  assign buf_we = ce && zx_col_q[0] && !zx_col_q[ZX_W-1];
  assign wcol   = zx_col_q[ZX_W-1] ? '1 : zx_col_q[BUF_AW:1];

  scandoubler_linebuf #(
    .PIX_W (PIX_W),
    .AW    (BUF_AW + 1)
  ) u_linebuf (
    .clk   (clk),
    .we    (buf_we),
    .waddr ({toggle_q, wcol}),
    .wdata (vid.v_in),
    .re    (ce),
    .raddr ({~toggle_q, sd_col_q[BUF_AW-1:0]}),
    .rdata (rd_data)
  );

  always_comb begin
    csync_prev_d = csync_prev_q;
    sync_len_d   = sync_len_q;
    line_cnt_d   = line_cnt_q;
    sd_col_d     = sd_col_q;
    zx_col_d     = zx_col_q;
    scanline_d   = scanline_q;
    toggle_d     = toggle_q;
    vs_d         = vs_q;
    fs_d         = fs_q;
    ctl_d        = ctl_q;
    hs_d         = hs_q;
    de_d         = de_q;
    v_d          = v_q;

    if (ce) begin
      csync_prev_d = vid.csync;
      sync_len_d   = vid.csync ? '0 : ((sync_len_q == SYNC_MAX) ? sync_len_q : sync_len_q + 1'b1);
      vs_d         = vid.csync ? 1'b0 : (vsync_det || vs_q);
      fs_d         = vsync_det;
      toggle_d     = toggle_q ^ line_edge;

      if (vsync_det)      line_cnt_d = '0;
      else if (line_edge) line_cnt_d = cnt_sat_inc(line_cnt_q);

      // An hsync edge landing on the wrap tick restarts the line once and flips scanline once.
      sd_col_d = (hsync_edge || col_wrap) ? '0 : sd_col_q + 1'b1;
      zx_col_d = hsync_edge ? '0 : ((&zx_col_q) ? zx_col_q : zx_col_q + 1'b1);

      if (vsync_det)                   scanline_d = 1'b0;
      else if (hsync_edge || col_wrap) scanline_d = ~scanline_q;

      ctl_d.hs   = (sd_col_q < HS_END_C);
      ctl_d.h_de = (sd_col_q >= HDE_START) && (sd_col_q < HDE_END);
      ctl_d.v_de = (line_cnt_q >= VDE_START) && (line_cnt_q < VDE_END);
      ctl_d.oob  = (sd_col_q >= BUF_COLS);
      ctl_d.dark = vid.scanlines && scanline_q;

      hs_d = ctl_q.hs;
      de_d = ctl_q.h_de && ctl_q.v_de;
      if (!de_d || ctl_q.oob) begin
        v_d = '0;
      end else if (ctl_q.dark) begin
`ifdef SCANLINE_DIM_EN
        v_d = rd_data >> 1;
`else
        v_d = '0;
`endif
      end else begin
        v_d = rd_data;
      end
    end
  end

  // Idle csync level is high so leaving reset never fakes a line edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csync_prev_q <= 1'b1;
      sync_len_q   <= '0;
      line_cnt_q   <= '0;
      sd_col_q     <= '0;
      zx_col_q     <= '0;
      scanline_q   <= 1'b0;
      toggle_q     <= 1'b0;
      vs_q         <= 1'b0;
      fs_q         <= 1'b0;
      ctl_q        <= '0;
      hs_q         <= 1'b0;
      de_q         <= 1'b0;
      v_q          <= '0;
    end else begin
      csync_prev_q <= csync_prev_d;
      sync_len_q   <= sync_len_d;
      line_cnt_q   <= line_cnt_d;
      sd_col_q     <= sd_col_d;
      zx_col_q     <= zx_col_d;
      scanline_q   <= scanline_d;
      toggle_q     <= toggle_d;
      vs_q         <= vs_d;
      fs_q         <= fs_d;
      ctl_q        <= ctl_d;
      hs_q         <= hs_d;
      de_q         <= de_d;
      v_q          <= v_d;
    end
  end

  assign vid.hs_out      = hs_q;
  assign vid.vs_out      = vs_q;
  assign vid.de_out      = de_q;
  assign vid.v_out       = v_q;
  assign vid.frame_start = fs_q;

endmodule

// File: tb/tb_scandoubler_gen.sv
// Scoreboard bench for scandoubler_gen: a full-size instance and a small-buffer
// instance share one stimulus stream and are checked against a reference model.
module tb_scandoubler_gen;

  localparam int LINE_LEN  = 414;
  localparam int VSYNC_LEN = 90;
  localparam int HS_END    = 384;
  localparam int H_DE_END  = 376;
  localparam int V_DE_END  = 296;
  localparam int PERIOD    = 828;
  localparam int HS_LOW    = 64;

  typedef struct packed {
    logic       hs;
    logic       de;
    logic [3:0] v;
    logic       known;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  scandoubler_gen_if #(.PIX_W(4)) vif_a ();
  scandoubler_gen_if #(.PIX_W(4)) vif_b ();

  scandoubler_gen #(.PIX_W(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .vid   (vif_a)
  );

  scandoubler_gen #(.PIX_W(4), .BUF_AW(4), .H_DE_START(0), .V_DE_START(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .vid   (vif_b)
  );

  int total = 0;
  int bad   = 0;
  int fsSeen;

  bit mPrev, mScan, mTog, mVs, mFs;
  int mSync, mLine, mZx, mSd;
  logic [3:0] mem  [2][2][512];
  bit         memv [2][2][512];
  exp_t expQa[$];
  exp_t expQb[$];
  exp_t lastA, lastB;

  function automatic int bufLen(input int k);
    return (k == 0) ? 512 : 16;
  endfunction

  function automatic int hdeStart(input int k);
    return (k == 0) ? 64 : 0;
  endfunction

  function automatic int vdeStart(input int k);
    return (k == 0) ? 17 : 2;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Expected pixel-path result for the column/line the DUT is addressing right now.
  function automatic exp_t predict(input int k, input bit scanIn);
    exp_t e;
    int   idx;
    e.hs    = (mSd < HS_END);
    e.de    = (mSd >= hdeStart(k)) && (mSd < H_DE_END) && (mLine >= vdeStart(k)) && (mLine < V_DE_END);
    e.v     = 4'h0;
    e.known = 1'b1;
    idx     = mSd % bufLen(k);
    if (e.de && (mSd < bufLen(k))) begin
      if (scanIn && mScan) begin
`ifdef SCANLINE_DIM_EN
        e.v     = mem[k][!mTog][idx] >> 1;
        e.known = memv[k][!mTog][idx];
`endif
      end else begin
        e.v     = mem[k][!mTog][idx];
        e.known = memv[k][!mTog][idx];
      end
    end
    return e;
  endfunction

  task automatic modelStep(input bit cs, input logic [3:0] pix);
    bit edgeSeen, hsEdge, vsDet, wrap;
    for (int k = 0; k < 2; k++) begin
      if ((mZx % 2 == 1) && (mZx / 2 < bufLen(k))) begin
        mem[k][mTog][mZx/2]  = pix;
        memv[k][mTog][mZx/2] = 1'b1;
      end
    end
    edgeSeen = cs && !mPrev;
    hsEdge   = edgeSeen && (mSync < VSYNC_LEN);
    vsDet    = !cs && (mSync == VSYNC_LEN);
    wrap     = (mSd == LINE_LEN - 1);
    mFs = vsDet;
    if (cs) mVs = 1'b0;
    else if (vsDet) mVs = 1'b1;
    if (vsDet) mLine = 0;
    else if (edgeSeen && mLine < 1023) mLine++;
    if (vsDet) mScan = 1'b0;
    else if (hsEdge || wrap) mScan = !mScan;
    if (edgeSeen) mTog = !mTog;
    mSd   = (hsEdge || wrap) ? 0 : mSd + 1;
    mZx   = hsEdge ? 0 : mZx + 1;
    mSync = cs ? 0 : ((mSync < 255) ? mSync + 1 : 255);
    mPrev = cs;
  endtask

  task automatic modelReset();
    exp_t z;
    z = '{hs: 1'b0, de: 1'b0, v: 4'h0, known: 1'b1};
    mPrev = 1'b1; mScan = 1'b0; mTog = 1'b0; mVs = 1'b0; mFs = 1'b0;
    mSync = 0; mLine = 0; mZx = 0; mSd = 0;
    foreach (memv[a, b, c]) memv[a][b][c] = 1'b0;
    expQa.delete();
    expQb.delete();
    expQa.push_back(z);
    expQb.push_back(z);
    lastA = z;
    lastB = z;
  endtask

  task automatic setInputs(input bit ce, input bit cs, input logic [3:0] pix, input bit scan);
    vif_a.ce_2pix = ce; vif_a.csync = cs; vif_a.v_in = pix; vif_a.scanlines = scan;
    vif_b.ce_2pix = ce; vif_b.csync = cs; vif_b.v_in = pix; vif_b.scanlines = scan;
  endtask

  task automatic checkDuts();
    checkOutput("a.hs_de", {vif_a.hs_out, vif_a.de_out}, {lastA.hs, lastA.de});
    if (lastA.known) checkOutput("a.v_out", vif_a.v_out, lastA.v);
    checkOutput("a.vs_fs", {vif_a.vs_out, vif_a.frame_start}, {mVs, mFs});
    checkOutput("b.hs_de", {vif_b.hs_out, vif_b.de_out}, {lastB.hs, lastB.de});
    if (lastB.known) checkOutput("b.v_out", vif_b.v_out, lastB.v);
    checkOutput("b.vs_fs", {vif_b.vs_out, vif_b.frame_start}, {mVs, mFs});
  endtask

  task automatic applyStimulus(input bit cs, input logic [3:0] pix, input bit scan);
    setInputs(1'b1, cs, pix, scan);
    expQa.push_back(predict(0, scan));
    expQb.push_back(predict(1, scan));
    modelStep(cs, pix);
    @(posedge clk);
    #1;
    lastA = expQa.pop_front();
    lastB = expQb.pop_front();
    if (vif_a.frame_start) fsSeen++;
    checkDuts();
  endtask

  // A clock with ce_2pix low and scrambled inputs must leave every output untouched.
  task automatic idleClock();
    setInputs(1'b0, 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
    @(posedge clk);
    #1;
    checkDuts();
  endtask

  task automatic runLine(input int lowLen, input int len, input int mode, input bit scan);
    logic [3:0] pix;
    for (int i = 0; i < len; i++) begin
      if (i % 97 == 50) idleClock();
      case (mode)
        0:       pix = 4'((i - lowLen) / 2);
        1:       pix = 4'hF;
        default: pix = 4'($urandom);
      endcase
      applyStimulus(i >= lowLen, pix, scan);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".a"}, {vif_a.hs_out, vif_a.vs_out, vif_a.de_out, vif_a.v_out, vif_a.frame_start}, 32'h0);
    checkOutput({tag, ".b"}, {vif_b.hs_out, vif_b.vs_out, vif_b.de_out, vif_b.v_out, vif_b.frame_start}, 32'h0);
  endtask

  initial begin
    setInputs(1'b0, 1'b1, 4'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("reset");
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] hsync lines");
    for (int n = 0; n < 3; n++) runLine(HS_LOW, PERIOD, 0, 1'b0);

    $display("[TB] vsync line");
    fsSeen = 0;
    runLine(100, PERIOD, 0, 1'b0);
    checkOutput("fs_count", fsSeen, 1);

    $display("[TB] doubled lines into the DE window");
    for (int n = 0; n < 20; n++) runLine(HS_LOW, PERIOD, 0, 1'b0);

    $display("[TB] scanlines");
    for (int n = 0; n < 4; n++) runLine(HS_LOW, PERIOD, 1, 1'b1);

    $display("[TB] random pixels");
    for (int n = 0; n < 2; n++) runLine(HS_LOW, PERIOD, 2, 1'b0);

    $display("[TB] async reset mid-line");
    for (int i = 0; i < PERIOD; i++) begin
      applyStimulus(i >= HS_LOW, 4'($urandom), 1'b0);
      if (i >= HS_LOW && mSd == 200) break;
    end
    checkOutput("pre_rst.hs", vif_a.hs_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    modelReset();
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) runLine(HS_LOW, PERIOD, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
